flag_collector: RTL and testbench
=================================

FLAG_COLLECTOR -- requirements
Module: flag_collector

Interface
REQ-001 SHALL have parameter F_WID, default 6, giving the number of flag lines (legal range 2..64).
REQ-002 SHALL have parameter A_WID, default $clog2(F_WID), giving the index width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port set_vec, input, F_WID, set strobes from the upstream one-hot address decoder; any bit pattern accepted.
REQ-006 SHALL have port mask, input, F_WID, service enable per flag (1 = eligible for presentation).
REQ-007 SHALL have port clr_ovr, input, 1, synchronous clear of all overrun bits.
REQ-008 SHALL have port out_valid, output, 1, an index is presented.
REQ-009 SHALL have port out_idx, output, A_WID, the presented flag index.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the presented index.
REQ-011 SHALL have port pending, output, F_WID, the registered pending-flag vector.
REQ-012 SHALL have port overrun, output, F_WID, sticky per-flag overrun status.

Function
REQ-013 SHALL, at every clock edge where set_vec[i]=1, set pending[i]=1; this is visible in the cycle after the edge.
REQ-014 SHALL implement a two-state FSM: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-015 SHALL, in IDLE when (pending & mask) != 0, register out_idx = lowest set index of (pending & mask), set out_valid=1 and go to HOLD.
  - Selection uses the registered pending vector, not set_vec.
  - Minimum latency: set at edge k, out_valid=1 after edge k+1.
REQ-016 SHALL, in IDLE when (pending & mask) == 0, stay in IDLE with out_valid=0.
REQ-017 SHALL, in HOLD, keep out_valid and out_idx stable until out_valid & out_ready is sampled at a clock edge.
  - This holds even if mask[out_idx] drops or set_vec changes.
REQ-018 SHALL, on acceptance at edge m:
  - clear pending[out_idx];
  - set out_valid=0 and go to IDLE;
  - leave out_valid low for exactly one cycle before the next presentation.
REQ-019 SHALL keep pending[out_idx]=1 when set_vec[out_idx]=1 at the acceptance edge; this is treated as a new event, so overrun is not set.
REQ-020 SHALL set overrun[i]=1 when set_vec[i]=1 while pending[i]=1 and bit i is not being cleared by acceptance at that edge.
REQ-021 SHALL keep overrun bits set until clr_ovr=1 at an edge. When clr_ovr and a new overrun condition for bit i occur at the same edge, overrun[i] SHALL be 1 (set wins).
REQ-022 SHALL let masked pending flags latch and record overruns normally; masking only suppresses presentation.
REQ-023 SHALL ignore out_ready while in IDLE.
REQ-024 SHALL treat the flag lines as independent bits: presentation order is lowest index first, re-evaluated after every acceptance, with no round-robin.

Reset
REQ-025 SHALL, while rst_n=0, immediately force state=IDLE, out_valid=0, out_idx=0, pending=0 and overrun=0, regardless of clk.
REQ-026 SHALL, when reset is asserted mid-HOLD, abandon the presented index without a transfer and lose all pending flags.
REQ-027 SHALL release from reset synchronously: the first state update occurs at the first rising clk edge with rst_n=1.

Verification (F_WID=6, A_WID=3)
REQ-028 Single event: mask=6'h3F, set_vec=6'b000100 for 1 cycle, out_ready=1 -> pending=6'b000100 after edge 1; out_valid=1, out_idx=2 after edge 2; pending=0 and out_valid=0 after edge 3.
REQ-029 Priority and stall: set_vec=6'b101001 for 1 cycle, out_ready=0 for 5 cycles then 1 -> out_idx=0 is held stable during the stall, then indices 0, 3, 5 are presented with one idle cycle between transfers.
REQ-030 Overrun: set bit 4 twice, 3 cycles apart, with out_ready=0 -> overrun=6'b010000, pending[4]=1; then clr_ovr=1 for 1 cycle -> overrun=0.
REQ-031 Same-edge set and accept: flag 1 is presented and set_vec=6'b000010 at the acceptance edge -> pending[1] stays 1, overrun[1]=0, and index 1 is presented again.
REQ-032 Mask: mask=6'b111110, set_vec=6'b000011 -> only index 1 is presented and pending=6'b000001 remains; then mask=6'h3F -> index 0 is presented.
REQ-033 Async reset mid-HOLD: drop rst_n between clock edges while out_valid=1 -> out_valid, pending and overrun go to 0 before the next edge, with no transfer recorded.

Source files
------------

// File: rtl/flag_collector.sv
// Collects per-line set strobes into a pending vector and presents the lowest
// unmasked pending index through a valid/ready handshake, tracking overruns.
//
// state | meaning
// IDLE  | nothing presented; scans pending & mask for the lowest set index
// HOLD  | out_idx presented with out_valid=1 until out_ready is sampled high
module flag_collector #(
    parameter int F_WID = 6,
    parameter int A_WID = $clog2(F_WID)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [F_WID-1:0] set_vec,
    input  logic [F_WID-1:0] mask,
    input  logic             clr_ovr,
    output logic             out_valid,
    output logic [A_WID-1:0] out_idx,
    input  logic             out_ready,
    output logic [F_WID-1:0] pending,
    output logic [F_WID-1:0] overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [F_WID-1:0] pending_q, pending_d;
    logic [F_WID-1:0] overrun_q, overrun_d;
    logic [A_WID-1:0] idx_q, idx_d;
    logic [F_WID-1:0] req_vec;
    logic [F_WID-1:0] clr_vec;
    logic [F_WID-1:0] ovr_set;
    logic [A_WID-1:0] low_idx;
    logic             any_req;
    logic             accept;
    logic             load_idx;

    // Downward scan so the last match written is the lowest index.
    always_comb begin
        req_vec = pending_q & mask;
        any_req = |req_vec;
        low_idx = '0;
        for (int i = F_WID - 1; i >= 0; i--) begin
            if (req_vec[i]) low_idx = A_WID'(i);
        end
    end

    always_comb begin
        accept  = (state_q == HOLD) && out_ready;
        clr_vec = '0;
        for (int i = 0; i < F_WID; i++) begin
            clr_vec[i] = accept && (idx_q == A_WID'(i));
        end
    end

    // A set coinciding with acceptance counts as a fresh event, not an overrun.
    always_comb begin
        ovr_set   = set_vec & pending_q & ~clr_vec;
        pending_d = (pending_q & ~clr_vec) | set_vec;
        overrun_d = clr_ovr ? ovr_set : (overrun_q | ovr_set);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            overrun_q <= '0;
            idx_q     <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            idx_q     <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == HOLD);
        load_idx  = (state_q == IDLE) && any_req;
        idx_d     = load_idx ? low_idx : idx_q;
    end

    assign out_idx = idx_q;
    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_flag_collector.sv
// Bench for flag_collector: directed scenarios plus randomized traffic, all
// compared every cycle against a flag-list reference model.
module tb_flag_collector;

    localparam int F = 6;
    localparam int A = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [F-1:0] set_vec = '0;
    logic [F-1:0] mask = '1;
    logic         clr_ovr = 1'b0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [A-1:0] out_idx;
    logic [F-1:0] pending;
    logic [F-1:0] overrun;

    int vectors = 0;
    int miscompares = 0;

    flag_collector #(.F_WID(F), .A_WID(A)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_vec   (set_vec),
        .mask      (mask),
        .clr_ovr   (clr_ovr),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .pending   (pending),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Reference: each flag is an independent boolean; the consumer side is
    // "presenting index m_idx or not".
    bit m_pend [F];
    bit m_ovr  [F];
    bit m_valid;
    int m_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < F; i++) begin
                m_pend[i] = 1'b0;
                m_ovr[i]  = 1'b0;
            end
            m_valid = 1'b0;
            m_idx   = 0;
        end else begin
            bit old_pend [F];
            bit taken;
            int pick;
            taken = m_valid && out_ready;
            for (int i = 0; i < F; i++) old_pend[i] = m_pend[i];
            for (int i = 0; i < F; i++) begin
                bit gone;
                gone = taken && (i == m_idx);
                if (set_vec[i] && old_pend[i] && !gone) m_ovr[i] = 1'b1;
                else if (clr_ovr) m_ovr[i] = 1'b0;
                if (set_vec[i]) m_pend[i] = 1'b1;
                else if (gone) m_pend[i] = 1'b0;
            end
            if (m_valid) begin
                if (taken) m_valid = 1'b0;
            end else begin
                pick = -1;
                for (int i = 0; i < F; i++) begin
                    if (pick < 0 && old_pend[i] && mask[i]) pick = i;
                end
                if (pick >= 0) begin
                    m_valid = 1'b1;
                    m_idx   = pick;
                end
            end
        end
    end

    function automatic logic [F-1:0] pack(input bit v [F]);
        logic [F-1:0] r;
        for (int i = 0; i < F; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("valid", 64'(out_valid), 64'(m_valid));
        chk("idx", 64'(out_idx), 64'(m_idx));
        chk("pending", 64'(pending), 64'(pack(m_pend)));
        chk("overrun", 64'(overrun), 64'(pack(m_ovr)));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk_model();
    endtask

    task automatic drain();
        set_vec   = '0;
        mask      = '1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) tick();
    endtask

    initial begin
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single event
        mask = 6'h3F; set_vec = 6'b000100; out_ready = 1'b1;
        tick();
        chk("single_pend", 64'(pending), 64'h04);
        chk("single_nv", 64'(out_valid), 64'd0);
        set_vec = '0;
        tick();
        chk("single_v", 64'(out_valid), 64'd1);
        chk("single_idx", 64'(out_idx), 64'd2);
        tick();
        chk("single_done", 64'({pending, out_valid}), 64'd0);

        // Priority and stall
        set_vec = 6'b101001; out_ready = 1'b0;
        tick();
        set_vec = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("stall_idx", 64'({out_valid, out_idx}), 64'({1'b1, 3'd0}));
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("prio_gap0", 64'(out_valid), 64'd0);
        tick();
        chk("prio_idx3", 64'({out_valid, out_idx}), 64'({1'b1, 3'd3}));
        tick();
        chk("prio_gap1", 64'(out_valid), 64'd0);
        tick();
        chk("prio_idx5", 64'({out_valid, out_idx}), 64'({1'b1, 3'd5}));
        tick();
        chk("prio_end", 64'({pending, out_valid}), 64'd0);

        // Overrun
        out_ready = 1'b0; set_vec = 6'b010000;
        tick();
        set_vec = '0;
        tick();
        tick();
        set_vec = 6'b010000;
        tick();
        set_vec = '0;
        chk("ovr_set", 64'(overrun), 64'h10);
        chk("ovr_pend4", 64'(pending[4]), 64'd1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_clr", 64'(overrun), 64'd0);
        drain();

        // Same-edge set and accept
        out_ready = 1'b0; set_vec = 6'b000010;
        tick();
        set_vec = '0;
        tick();
        chk("same_pres", 64'({out_valid, out_idx}), 64'({1'b1, 3'd1}));
        out_ready = 1'b1; set_vec = 6'b000010;
        tick();
        set_vec = '0;
        chk("same_pend1", 64'(pending[1]), 64'd1);
        chk("same_ovr1", 64'(overrun[1]), 64'd0);
        tick();
        chk("same_again", 64'({out_valid, out_idx}), 64'({1'b1, 3'd1}));
        tick();

        // Mask
        mask = 6'b111110; set_vec = 6'b000011;
        tick();
        set_vec = '0;
        tick();
        chk("mask_idx1", 64'({out_valid, out_idx}), 64'({1'b1, 3'd1}));
        tick();
        tick();
        chk("mask_hold", 64'({pending, out_valid}), 64'({6'b000001, 1'b0}));
        mask = 6'h3F;
        tick();
        chk("mask_idx0", 64'({out_valid, out_idx}), 64'({1'b1, 3'd0}));
        tick();

        // Async reset while presenting
        out_ready = 1'b0; set_vec = 6'b000100;
        tick();
        tick();
        set_vec = '0;
        chk("ar_pre", 64'({out_valid, overrun}), 64'({1'b1, 6'b000100}));
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_state", 64'({pending, overrun}), 64'd0);
        @(negedge clk);
        chk_model();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("ar_after", 64'(out_valid), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            set_vec   = ($urandom_range(0, 2) == 0) ? F'($urandom) : '0;
            mask      = ($urandom_range(0, 3) == 0) ? F'($urandom) : '1;
            out_ready = ($urandom_range(0, 2) != 0);
            clr_ovr   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #($urandom_range(1, 8)) rst_n = 1'b0;
                #1;
                chk_model();
                @(negedge clk);
                rst_n = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
